// File: rtl/vx_wb_arbiter_pkg.sv
// Shared types for the per-issue-slot writeback arbiter: commit/writeback beats,
// arbiter FSM states and small index helpers.
package vx_wb_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int NR_BITS     = 5;
  localparam int UUID_W      = 16;
  localparam int THREAD_CNT  = 4;
  localparam int WARP_CNT    = 8;
  localparam int ISSUE_CNT   = (WARP_CNT < 4) ? WARP_CNT : 4;
  localparam int ISSUE_WIS_W = ((WARP_CNT / ISSUE_CNT) > 1) ? $clog2(WARP_CNT / ISSUE_CNT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [UUID_W-1:0]                  uuid;
    logic [ISSUE_WIS_W-1:0]             wis;
    logic [THREAD_CNT-1:0]              tmask;
    logic [XLEN-1:0]                    pc;
    logic                               wb;
    logic [NR_BITS-1:0]                 rd;
    logic [THREAD_CNT-1:0][XLEN-1:0]    data;
    logic                               sop;
    logic                               eop;
  } commit_t;

  typedef struct packed {
    logic [UUID_W-1:0]                  uuid;
    logic [ISSUE_WIS_W-1:0]             wis;
    logic [THREAD_CNT-1:0]              tmask;
    logic [XLEN-1:0]                    pc;
    logic [NR_BITS-1:0]                 rd;
    logic [THREAD_CNT-1:0][XLEN-1:0]    data;
    logic                               sop;
    logic                               eop;
  } writeback_t;

  localparam int COMMIT_W = $bits(commit_t);
  localparam int WB_W     = $bits(writeback_t);

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return wrap_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/vx_wb_arbiter_rr.sv
// Round-robin arbiter with a packet lock: once a multi-beat packet starts, the
// owning requester keeps the grant until it signals unlock.
module vx_wb_arbiter_rr
  import vx_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               lock,
  input  logic               unlock,
  output logic [NUM_SRC-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               locked
);

  wb_state_e        state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] scan_idx;
  logic             scan_hit;

  assign locked = (state_q == LOCKED);

  // Walk offsets from the far end down so the requester closest to rr_ptr wins.
  always_comb begin
    scan_idx = rr_ptr_q;
    scan_hit = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[IDX_W'(wrap_add(int'(rr_ptr_q), i, NUM_SRC))]) begin
        scan_idx = IDX_W'(wrap_add(int'(rr_ptr_q), i, NUM_SRC));
        scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx    = locked ? lock_idx_q : scan_idx;
    grant_valid  = locked | scan_hit;
    grant_onehot = '0;
    if (grant_valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (lock) begin
          state_d    = LOCKED;
          lock_idx_d = grant_idx;
        end else if (unlock) begin
          rr_ptr_d = IDX_W'(next_idx(int'(grant_idx), NUM_SRC));
        end
      end
      LOCKED: begin
        if (unlock) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(next_idx(int'(lock_idx_q), NUM_SRC));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/vx_wb_arbiter.sv
// Merges execute-unit commit streams into one registered GPR writeback stream,
// keeping multi-beat packets atomic and counting retired instructions.
module vx_wb_arbiter
  import vx_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PERF_W  = 44
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          commit_valid,
  input  logic [NUM_SRC*COMMIT_W-1:0] commit_data,
  output logic [NUM_SRC-1:0]          commit_ready,
  output logic                        wb_valid,
  output logic [WB_W-1:0]             wb_data,
  output logic [PERF_W-1:0]           perf_commits
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  commit_t          beat [NUM_SRC];
  commit_t          sel;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             locked;
  logic             accepted;

  logic              wb_valid_q, wb_valid_d;
  writeback_t        wb_data_q, wb_data_d;
  logic [PERF_W-1:0] perf_commits_q, perf_commits_d;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign beat[gi] = commit_data[gi*COMMIT_W +: COMMIT_W];
    end
  endgenerate

  assign sel      = beat[grant_idx];
  assign accepted = grant_valid & commit_valid[grant_idx];

  vx_wb_arbiter_rr #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (commit_valid),
    .lock         (accepted & ~sel.eop),
    .unlock       (accepted & sel.eop),
    .grant_onehot (commit_ready),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .locked       (locked)
  );

  // Non-writing beats are consumed but leave the output data register untouched.
  always_comb begin
    wb_valid_d     = accepted & sel.wb;
    wb_data_d      = wb_data_q;
    perf_commits_d = perf_commits_q + PERF_W'(accepted & sel.eop);
    if (wb_valid_d) begin
      wb_data_d.uuid  = sel.uuid;
      wb_data_d.wis   = sel.wis;
      wb_data_d.tmask = sel.tmask;
      wb_data_d.pc    = sel.pc;
      wb_data_d.rd    = sel.rd;
      wb_data_d.data  = sel.data;
      wb_data_d.sop   = sel.sop;
      wb_data_d.eop   = sel.eop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      perf_commits_q <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      perf_commits_q <= perf_commits_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign perf_commits = perf_commits_q;

`ifndef SYNTHESIS
  // A packet must open with sop outside a lock and never restart inside one.
  assert property (@(posedge clk) disable iff (reset) accepted |-> (sel.sop == !locked));

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_proto
      assert property (@(posedge clk) disable iff (reset)
        (commit_valid[gi] && !commit_ready[gi]) |=> commit_valid[gi]);
      assert property (@(posedge clk) disable iff (reset)
        (commit_valid[gi] && !commit_ready[gi]) |=> $stable(commit_data[gi*COMMIT_W +: COMMIT_W]));
    end
  endgenerate
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter: single beats, round-robin, packet lock,
// wb=0 drop, counter wrap and asynchronous reset mid-packet.
module tb_vx_wb_arbiter;
  import vx_wb_arbiter_pkg::*;

  localparam int NSRC = 4;
  localparam int PW   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NSRC-1:0]          vld;
  logic [NSRC*COMMIT_W-1:0] commit_data;
  logic [NSRC-1:0]          commit_ready;
  logic                     wb_valid;
  logic [WB_W-1:0]          wb_data;
  logic [PW-1:0]            perf_commits;

  commit_t       src [NSRC];
  writeback_t    wb_hold;
  logic [PW-1:0] exp_perf;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pack
      assign commit_data[gi*COMMIT_W +: COMMIT_W] = src[gi];
    end
  endgenerate

  vx_wb_arbiter #(
    .NUM_SRC (NSRC),
    .PERF_W  (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (vld),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .perf_commits (perf_commits)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic commit_t mk(input logic [15:0] uuid, input logic wis, input logic [3:0] tmask,
                                 input logic [31:0] pc, input logic wb, input logic [4:0] rd,
                                 input logic [31:0] lane0, input logic sop, input logic eop);
    commit_t c;
    c.uuid  = uuid;
    c.wis   = wis;
    c.tmask = tmask;
    c.pc    = pc;
    c.wb    = wb;
    c.rd    = rd;
    for (int k = 0; k < THREAD_CNT; k++) c.data[k] = lane0 + 32'(k * 16);
    c.sop   = sop;
    c.eop   = eop;
    return c;
  endfunction

  function automatic logic [255:0] wbx(input commit_t c);
    writeback_t w;
    w.uuid  = c.uuid;
    w.wis   = c.wis;
    w.tmask = c.tmask;
    w.pc    = c.pc;
    w.rd    = c.rd;
    w.data  = c.data;
    w.sop   = c.sop;
    w.eop   = c.eop;
    return 256'(w);
  endfunction

  task automatic expect_perf(input string tag);
    check(tag, 256'(perf_commits), 256'(exp_perf));
  endtask

  initial begin
    logic [1:0] g;
    reset = 1'b1;
    vld   = '0;
    for (int k = 0; k < NSRC; k++) src[k] = '0;
    exp_perf = '0;
    tick();
    tick();
    check("rst_wb_valid", 256'(wb_valid), 256'(1'b0));
    check("rst_wb_data", 256'(wb_data), 256'(0));
    check("rst_perf", 256'(perf_commits), 256'(0));
    check("rst_ready", 256'(commit_ready), 256'(4'b0000));
    reset = 1'b0;
    tick();

    // single beat from src2
    src[2] = mk(16'h0011, 1'b1, 4'b1011, 32'h0000_1000, 1'b1, 5'd5, 32'h0000_00AA, 1'b1, 1'b1);
    vld = 4'b0100;
    #1 check("t1_ready", 256'(commit_ready), 256'(4'b0100));
    tick();
    vld = '0;
    check("t1_wb_valid", 256'(wb_valid), 256'(1'b1));
    check("t1_wb_data", 256'(wb_data), wbx(src[2]));
    exp_perf = 4'd1;
    expect_perf("t1_perf");

    // rr_ptr is now 3: src3 beats src1, then src1 follows
    src[1] = mk(16'h0021, 1'b0, 4'b1111, 32'h0000_1100, 1'b1, 5'd6, 32'h0000_00B1, 1'b1, 1'b1);
    src[3] = mk(16'h0023, 1'b1, 4'b0001, 32'h0000_1300, 1'b1, 5'd7, 32'h0000_00B3, 1'b1, 1'b1);
    vld = 4'b1010;
    #1 check("t2_ready_a", 256'(commit_ready), 256'(4'b1000));
    tick();
    vld[3] = 1'b0;
    check("t2_wb_data_a", 256'(wb_data), wbx(src[3]));
    #1 check("t2_ready_b", 256'(commit_ready), 256'(4'b0010));
    tick();
    vld[1] = 1'b0;
    check("t2_wb_data_b", 256'(wb_data), wbx(src[1]));
    exp_perf = 4'd3;
    expect_perf("t2_perf");

    // bring rr_ptr back to 0 via src3
    src[3] = mk(16'h0029, 1'b0, 4'b0110, 32'h0000_1900, 1'b1, 5'd9, 32'h0000_00B9, 1'b1, 1'b1);
    vld = 4'b1000;
    #1 check("t3_ready", 256'(commit_ready), 256'(4'b1000));
    tick();
    vld = '0;
    exp_perf = 4'd4;

    // round robin: all four valid, expect 0,1,2,3,0,1,2,3 then drain
    for (int k = 0; k < NSRC; k++)
      src[k] = mk(16'(16'h0030 + k), 1'(k), 4'(k + 1), 32'(32'h2000 + k * 4), 1'b1, 5'(8 + k),
                  32'(32'hC0 + k), 1'b1, 1'b1);
    vld = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      g = 2'(i % 4);
      #1 check($sformatf("rr_ready_%0d", i), 256'(commit_ready), 256'(4'b0001 << g));
      tick();
      check($sformatf("rr_wb_valid_%0d", i), 256'(wb_valid), 256'(1'b1));
      check($sformatf("rr_wb_data_%0d", i), 256'(wb_data), wbx(src[g]));
      if (i < 4) src[g].uuid = src[g].uuid + 16'h0100;
      else       vld[g] = 1'b0;
    end
    exp_perf = 4'd12;
    expect_perf("rr_perf");

    // multi-beat packet from src1 with idle gaps, src0/src3 must stall
    src[1] = mk(16'h0041, 1'b1, 4'b0011, 32'h0000_3000, 1'b1, 5'd10, 32'h0000_00D0, 1'b1, 1'b0);
    vld = 4'b0010;
    #1 check("mb_ready_sop", 256'(commit_ready), 256'(4'b0010));
    tick();
    vld = '0;
    check("mb_wb_sop", 256'(wb_data), wbx(src[1]));
    expect_perf("mb_perf_sop");
    src[0] = mk(16'h0050, 1'b0, 4'b1000, 32'h0000_3100, 1'b1, 5'd11, 32'h0000_00E0, 1'b1, 1'b1);
    src[3] = mk(16'h0053, 1'b1, 4'b0100, 32'h0000_3300, 1'b1, 5'd12, 32'h0000_00E3, 1'b1, 1'b1);
    vld = 4'b1001;
    for (int b = 1; b < 3; b++) begin
      for (int gap = 0; gap < 2; gap++) begin
        #1 check($sformatf("mb_gap_ready_%0d_%0d", b, gap), 256'(commit_ready), 256'(4'b0010));
        tick();
        check($sformatf("mb_gap_wbv_%0d_%0d", b, gap), 256'(wb_valid), 256'(1'b0));
      end
      src[1] = mk(16'h0041, 1'b1, 4'b0011, 32'h0000_3000, 1'b1, 5'd10, 32'(32'hD0 + b), 1'b0, 1'(b == 2));
      vld[1] = 1'b1;
      #1 check($sformatf("mb_ready_%0d", b), 256'(commit_ready), 256'(4'b0010));
      tick();
      vld[1] = 1'b0;
      check($sformatf("mb_wb_%0d", b), 256'(wb_data), wbx(src[1]));
    end
    exp_perf = 4'd13;
    expect_perf("mb_perf_eop");
    #1 check("mb_next_src3", 256'(commit_ready), 256'(4'b1000));
    tick();
    vld[3] = 1'b0;
    check("mb_wb_src3", 256'(wb_data), wbx(src[3]));
    #1 check("mb_next_src0", 256'(commit_ready), 256'(4'b0001));
    tick();
    vld[0] = 1'b0;
    check("mb_wb_src0", 256'(wb_data), wbx(src[0]));
    wb_hold  = writeback_t'(wbx(src[0]));
    exp_perf = 4'd15;
    expect_perf("mb_perf_final");

    // wb=0 drop, also wraps the counter 15 -> 0
    src[0] = mk(16'h0060, 1'b1, 4'b1111, 32'h0000_4000, 1'b0, 5'd13, 32'h0000_00EE, 1'b1, 1'b1);
    vld = 4'b0001;
    #1 check("drop_ready", 256'(commit_ready), 256'(4'b0001));
    tick();
    vld = '0;
    check("drop_wb_valid", 256'(wb_valid), 256'(1'b0));
    check("drop_wb_hold", 256'(wb_data), 256'(wb_hold));
    exp_perf = 4'd0;
    expect_perf("drop_perf_wrap");

    // rr_ptr to 3, then only src0 valid wraps around
    src[2] = mk(16'h0062, 1'b0, 4'b0101, 32'h0000_4200, 1'b1, 5'd14, 32'h0000_00F2, 1'b1, 1'b1);
    vld = 4'b0100;
    #1 check("wrap_ready_src2", 256'(commit_ready), 256'(4'b0100));
    tick();
    vld = '0;
    src[0] = mk(16'h0070, 1'b1, 4'b1001, 32'h0000_4400, 1'b1, 5'd15, 32'h0000_00F0, 1'b1, 1'b1);
    vld = 4'b0001;
    #1 check("wrap_ready_src0", 256'(commit_ready), 256'(4'b0001));
    tick();
    vld = '0;
    check("wrap_wb_data", 256'(wb_data), wbx(src[0]));
    exp_perf = 4'd2;
    expect_perf("wrap_perf");

    // asynchronous reset while locked on src2
    src[2] = mk(16'h0080, 1'b1, 4'b1110, 32'h0000_5000, 1'b1, 5'd16, 32'h0000_0110, 1'b1, 1'b0);
    vld = 4'b0100;
    #1 check("rst_mp_ready_sop", 256'(commit_ready), 256'(4'b0100));
    tick();
    vld = '0;
    check("rst_mp_wbv_sop", 256'(wb_valid), 256'(1'b1));
    src[0] = mk(16'h0090, 1'b0, 4'b0111, 32'h0000_5100, 1'b1, 5'd17, 32'h0000_0120, 1'b1, 1'b1);
    vld = 4'b0001;
    #1 check("rst_mp_locked", 256'(commit_ready), 256'(4'b0100));
    #1 reset = 1'b1;
    #1;
    check("rst_mp_wbv", 256'(wb_valid), 256'(1'b0));
    check("rst_mp_perf", 256'(perf_commits), 256'(0));
    vld = '0;
    tick();
    tick();
    reset = 1'b0;
    vld = 4'b0001;
    #1 check("rst_mp_ready_src0", 256'(commit_ready), 256'(4'b0001));
    tick();
    vld = '0;
    check("rst_mp_wbv_src0", 256'(wb_valid), 256'(1'b1));
    check("rst_mp_wb_src0", 256'(wb_data), wbx(src[0]));
    exp_perf = 4'd1;
    expect_perf("rst_mp_perf_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
